board_uart_tx: RTL and testbench

Serialises the 188-bit board snapshot from the framebuffer analyzer to the host-side AI over a UART link. The snapshot holds 180 playfield cells (row-major, top-left first) and 8 next-piece preview cells. On each end-of-frame pulse the block snapshots the board and sends it as 188 ASCII '0'/'1' characters followed by a line feed. It sits directly downstream of the analyzer and drives the FPGA's UART TX pin.

---
 rtl/board_tx_pkg.sv | 17 +
 rtl/uart_tx_byte.sv | 73 +++++++
 rtl/board_uart_tx.sv | 101 ++++++++++
 tb/tb_board_uart_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/board_tx_pkg.sv
// Shared types and constants for the board-snapshot UART transmitter.
package board_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_1  = 8'h31;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int MSG_CHARS = 189;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. A start accepted while o_ready is high begins the next
// character; accepting on the final stop-bit cycle chains characters with no gap.
module uart_tx_byte
    import board_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic              w_wrap;

    assign w_wrap  = (r_baud == BAUD_LAST);
    assign o_ready = (r_state == IDLE) || ((r_state == STOP) && w_wrap);
    assign o_tx    = r_tx;

    // NOTE: all sequential state uses non-blocking assignments so every register
    // sees pre-edge values; the async reset forces the line idle with no clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else if (r_state == IDLE) begin
            if (i_start) begin
                r_state <= START;
                r_baud  <= '0;
                r_shift <= i_data;
                r_tx    <= 1'b0;
            end
        end else if (!w_wrap) begin
            r_baud <= r_baud + BAUD_W'(1);
        end else begin
            r_baud <= '0;
            if (r_state == START) begin
                r_state   <= DATA;
                r_bit_idx <= '0;
                r_tx      <= r_shift[0];
            end else if (r_state == DATA) begin
                if (r_bit_idx == 3'd7) begin
                    r_state <= STOP;
                    r_tx    <= 1'b1;
                end else begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                    r_shift   <= r_shift >> 1;
                    r_tx      <= r_shift[1];
                end
            end else if (i_start) begin
                r_state <= START;
                r_shift <= i_data;
                r_tx    <= 1'b0;
            end else begin
                r_state <= IDLE;
            end
        end
    end

endmodule

// File: rtl/board_uart_tx.sv
// Sends the board snapshot as ASCII '0'/'1' characters plus LF over UART.
// Optional macro BOARD_TX_CHANGE_ONLY_EN suppresses resending an unchanged board.
module board_uart_tx
    import board_tx_pkg::*;
#(
    parameter int BITS_AMOUNT  = MSG_CHARS - 1,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [BITS_AMOUNT-1:0] boardString,
    input  logic                   frame_done,
    output logic                   tx,
    output logic                   busy,
    output logic [7:0]             sent_count
);

    localparam int               IDX_W        = $clog2(BITS_AMOUNT + 1);
    localparam logic [IDX_W-1:0] LAST_BIT_IDX = IDX_W'(BITS_AMOUNT - 1);
    localparam logic [IDX_W-1:0] LF_IDX       = IDX_W'(BITS_AMOUNT);

    logic [BITS_AMOUNT-1:0] r_snapshot;
    logic [IDX_W-1:0]       r_char_idx;
    logic                   r_busy;
    logic [7:0]             r_sent_count;

    logic       w_allowed;
    logic       w_capture;
    logic       w_advance;
    logic       w_ready;
    logic [7:0] w_char;
    logic       w_tx;

`ifdef BOARD_TX_CHANGE_ONLY_EN
    logic                   r_captured;
    logic [BITS_AMOUNT-1:0] r_last_sent;

    assign w_allowed = !r_captured || (boardString != r_last_sent);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_captured  <= 1'b0;
            r_last_sent <= '0;
        end else if (w_capture) begin
            r_captured  <= 1'b1;
            r_last_sent <= boardString;
        end
    end
`else
    assign w_allowed = 1'b1;
`endif

    assign w_capture = !r_busy && frame_done && w_allowed;
    assign w_advance = r_busy && w_ready && (r_char_idx != LF_IDX);

    // The snapshot shifts left once per character, so its MSB is always the next board bit.
    always_comb begin
        if (w_capture) begin
            w_char = boardString[BITS_AMOUNT-1] ? ASCII_1 : ASCII_0;
        end else if (r_char_idx == LAST_BIT_IDX) begin
            w_char = ASCII_LF;
        end else begin
            w_char = r_snapshot[BITS_AMOUNT-1] ? ASCII_1 : ASCII_0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snapshot   <= '0;
            r_char_idx   <= '0;
            r_busy       <= 1'b0;
            r_sent_count <= '0;
        end else if (w_capture) begin
            r_snapshot   <= boardString << 1;
            r_char_idx   <= '0;
            r_busy       <= 1'b1;
            r_sent_count <= r_sent_count + 8'd1;
        end else if (w_advance) begin
            r_snapshot <= r_snapshot << 1;
            r_char_idx <= r_char_idx + IDX_W'(1);
        end else if (r_busy && w_ready) begin
            r_busy <= 1'b0;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_start(w_capture || w_advance),
        .i_data (w_char),
        .o_ready(w_ready),
        .o_tx   (w_tx)
    );

    assign tx         = w_tx;
    assign busy       = r_busy;
    assign sent_count = r_sent_count;

endmodule

// File: tb/tb_board_uart_tx.sv
// Scoreboard bench for board_uart_tx: expected boards are queued at each
// accepted frame_done and a UART receiver process decodes and compares.
module tb_board_uart_tx;

    localparam int BITS        = 188;
    localparam int CPB         = 4;
    localparam int MSG         = 189;
    localparam int BUSY_CYCLES = MSG * 10 * CPB;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            frame_done;
    logic [BITS-1:0] board;
    logic            tx;
    logic            busy;
    logic [7:0]      sent_count;

    int              n_checks = 0;
    int              n_fail   = 0;
    int              rx_msgs  = 0;
    logic [BITS-1:0] exp_q[$];

    always #5 clk = ~clk;

    board_uart_tx #(
        .BITS_AMOUNT (BITS),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .boardString(board),
        .frame_done (frame_done),
        .tx         (tx),
        .busy       (busy),
        .sent_count (sent_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // UART receiver and scoreboard comparison.
    initial begin : rx_monitor
        logic [7:0]      rx_q[$];
        logic [7:0]      b;
        logic [7:0]      ch;
        logic [7:0]      want;
        logic [BITS-1:0] e;
        logic            ok;
        int              bad;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rx_q.delete();
            end else if (tx === 1'b0) begin
                ok = 1'b1;
                b  = '0;
                @(negedge clk);
                ok = ok & rst_n;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    ok = ok & rst_n;
                    b  = {tx, b[7:1]};
                end
                repeat (CPB) @(negedge clk);
                ok = ok & rst_n;
                if (!ok) begin
                    rx_q.delete();
                end else begin
                    check("stop_bit", tx, 1);
                    rx_q.push_back(b);
                    if (b == 8'h0A || rx_q.size() == MSG) begin
                        rx_msgs++;
                        check("msg_len", rx_q.size(), MSG);
                        check("msg_was_expected", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) begin
                            e   = exp_q.pop_front();
                            bad = MSG;
                            for (int k = 0; k < BITS; k++) begin
                                ch   = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
                                want = e[BITS-1] ? 8'h31 : 8'h30;
                                if (ch !== want && bad == MSG) bad = k;
                                e = e << 1;
                            end
                            check("msg_first_bad_char", bad, MSG);
                            ch = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
                            check("msg_trailing_lf", ch, 8'h0A);
                        end
                        rx_q.delete();
                    end
                end
            end
        end
    end

    initial begin : busy_monitor
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cnt = 0;
            end else if (busy) begin
                cnt++;
            end else if (cnt != 0) begin
                check("busy_cycles", cnt, BUSY_CYCLES);
                cnt = 0;
            end
        end
    end

    task automatic pulse(input logic [BITS-1:0] v);
        @(negedge clk);
        board      = v;
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while (busy && i < 2 * BUSY_CYCLES) begin
            @(negedge clk);
            i++;
        end
        check(name, busy, 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin : stimulus
        logic [BITS-1:0] p_one_hot;
        logic [BITS-1:0] p_stripe;
        logic [BITS-1:0] p_same;
        logic [BITS-1:0] p_reset;
        int              exp_cnt;
        int              bad;

        rst_n      = 1'b1;
        frame_done = 1'b0;
        board      = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", sent_count, 0);
        rst_n = 1'b1;

        // Idle line stays quiet.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || sent_count !== 8'd0) bad++;
        end
        check("idle_quiet_cycles_bad", bad, 0);

        // Single one in the first-sent position; an overlapping frame_done is dropped.
        exp_cnt   = 0;
        p_one_hot = '0;
        p_one_hot[BITS-1] = 1'b1;
        exp_q.push_back(p_one_hot);
        pulse(p_one_hot);
        exp_cnt++;
        check("cap_busy", busy, 1);
        check("cap_tx_start", tx, 0);
        check("cap_count", sent_count, exp_cnt);
        repeat (20) @(negedge clk);
        pulse('1);
        check("drop_busy", busy, 1);
        check("drop_count", sent_count, exp_cnt);
        wait_idle("msg1_done");
        check("msg1_rx", rx_msgs, 1);

        // Board toggles every cycle after capture; message must hold the captured value.
        p_stripe = {47{4'b1100}};
        exp_q.push_back(p_stripe);
        pulse(p_stripe);
        exp_cnt++;
        for (int i = 0; i < 300; i++) begin
            board = ~board;
            @(negedge clk);
        end
        wait_idle("msg2_done");
        check("msg2_count", sent_count, exp_cnt);
        check("msg2_rx", rx_msgs, 2);

        // Identical board twice.
        p_same = {47{4'b1001}};
        exp_q.push_back(p_same);
        pulse(p_same);
        exp_cnt++;
        wait_idle("msg3_done");
`ifdef BOARD_TX_CHANGE_ONLY_EN
        pulse(p_same);
        check("same_board_busy", busy, 0);
        repeat (50) @(negedge clk);
`else
        exp_q.push_back(p_same);
        pulse(p_same);
        exp_cnt++;
        check("same_board_busy", busy, 1);
        wait_idle("msg4_done");
`endif
        check("same_board_count", sent_count, exp_cnt);
        check("same_board_rx", rx_msgs, exp_cnt);

        // Reset during DATA of character 50, then a full message from char 0.
        p_reset = {47{4'b0110}};
        exp_q.push_back(p_reset);
        pulse(p_reset);
        repeat (50 * 10 * CPB + 2 * CPB + 2) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_count", sent_count, 0);
        exp_q.delete();
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        bad = rx_msgs;
        exp_q.push_back(p_reset);
        pulse(p_reset);
        check("post_rst_count", sent_count, 1);
        wait_idle("msg_post_rst_done");
        check("post_rst_rx", rx_msgs, bad + 1);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
